poly_term_feeder: RTL

Upstream stage of the MAC unit in the nonlinear approximation engine. Accepts one fixed-point sample x per handshake, selects a polynomial segment from the top bits of x, and emits ORDER+1 word pairs: the power term x^k and the coefficient c[seg][k], for k = 0..ORDER. Each pair is pushed into the MAC's signal and coefficient FIFOs while honouring their full flags. Coefficients are held in an internal register bank loaded through a simple config write port.

---
 rtl/nla_pkg.sv | 13 +
 rtl/fxp_mul.sv | 13 +
 rtl/poly_term_feeder.sv | 113 +++++++++++
 3 files changed

// File: rtl/nla_pkg.sv
// nla_pkg: shared FSM encoding and fixed-point helpers for the nonlinear approximation engine
package nla_pkg;
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_EMIT = 1'b1;

    function automatic int cidx_w(input int order);
        return $clog2(order + 1);
    endfunction

    function automatic logic [63:0] one_q(input int frac_bits);
        return 64'd1 << frac_bits;
    endfunction
endpackage

// File: rtl/fxp_mul.sv
// fxp_mul: signed fixed-point multiply, product shifted right by FRAC_BITS and truncated
module fxp_mul #(
    parameter int DATA_WIDTH = 32,
    parameter int FRAC_BITS  = 16
) (
    input  logic [DATA_WIDTH-1:0] i_a,
    input  logic [DATA_WIDTH-1:0] i_b,
    output logic [DATA_WIDTH-1:0] o_p
);
    logic [2*DATA_WIDTH-1:0] w_prod;
    assign w_prod = {{DATA_WIDTH{i_a[DATA_WIDTH-1]}}, i_a} * {{DATA_WIDTH{i_b[DATA_WIDTH-1]}}, i_b};
    assign o_p    = DATA_WIDTH'(w_prod >> FRAC_BITS);
endmodule

// File: rtl/poly_term_feeder.sv
// poly_term_feeder: expands each sample into ORDER+1 (x^k, c[seg][k]) pairs pushed into the MAC FIFOs
module poly_term_feeder
    import nla_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int FRAC_BITS  = 16,
    parameter int ORDER      = 3,
    parameter int SEG_BITS   = 2,
    localparam int CIDX_W    = cidx_w(ORDER)
) (
    input  logic                       clk_i,
    input  logic                       rstn_i,
    input  logic [DATA_WIDTH-1:0]      x_i,
    input  logic                       x_valid_i,
    output logic                       x_ready_o,
    input  logic                       cfg_we_i,
    input  logic [SEG_BITS+CIDX_W-1:0] cfg_addr_i,
    input  logic [DATA_WIDTH-1:0]      cfg_data_i,
    output logic                       cfg_err_o,
    input  logic                       full_sig_i,
    input  logic                       full_coeff_i,
    output logic                       push_o,
    output logic [DATA_WIDTH-1:0]      sig_data_o,
    output logic [DATA_WIDTH-1:0]      coeff_data_o,
    output logic                       busy_o,
    output logic                       done_o
);
    localparam int NW = (1 << SEG_BITS) * (ORDER + 1);
    localparam int IW = $clog2(NW);
    localparam logic [DATA_WIDTH-1:0] ONE_Q = DATA_WIDTH'(one_q(FRAC_BITS));

    logic [0:0]            r_state;
    logic [DATA_WIDTH-1:0] r_x;
    logic [DATA_WIDTH-1:0] r_p;
    logic [SEG_BITS-1:0]   r_seg;
    logic [CIDX_W-1:0]     r_k;
    logic                  r_cfg_err;
    logic [DATA_WIDTH-1:0] r_bank [NW];

    logic                  w_idle;
    logic                  w_push;
    logic                  w_last;
    logic                  w_cfg_ok;
    logic [SEG_BITS-1:0]   w_cfg_seg;
    logic [CIDX_W-1:0]     w_cfg_k;
    logic [IW-1:0]         w_widx;
    logic [IW-1:0]         w_ridx;
    logic [DATA_WIDTH-1:0] w_p_next;

    assign w_idle    = (r_state == ST_IDLE);
    assign w_push    = !w_idle && !full_sig_i && !full_coeff_i;
    assign w_last    = (r_k == CIDX_W'(ORDER));
    assign w_cfg_seg = cfg_addr_i[CIDX_W +: SEG_BITS];
    assign w_cfg_k   = cfg_addr_i[CIDX_W-1:0];
    assign w_cfg_ok  = cfg_we_i && w_idle && (w_cfg_k <= CIDX_W'(ORDER));
    assign w_widx    = IW'(w_cfg_seg * (ORDER + 1)) + IW'(w_cfg_k);
    assign w_ridx    = IW'(r_seg * (ORDER + 1)) + IW'(r_k);

    assign x_ready_o    = w_idle;
    assign busy_o       = !w_idle;
    assign push_o       = w_push;
    assign done_o       = w_push && w_last;
    assign cfg_err_o    = r_cfg_err;
    assign sig_data_o   = r_p;
    assign coeff_data_o = r_bank[w_ridx];

    fxp_mul #(
        .DATA_WIDTH (DATA_WIDTH),
        .FRAC_BITS  (FRAC_BITS)
    ) u_mul (
        .i_a (r_p),
        .i_b (r_x),
        .o_p (w_p_next)
    );

    // Burst control: latch sample on accept, advance power and term index on every push
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_state <= ST_IDLE;
            r_x     <= '0;
            r_p     <= '0;
            r_seg   <= '0;
            r_k     <= '0;
        end else if (w_idle) begin
            if (x_valid_i) begin
                r_state <= ST_EMIT;
                r_x     <= x_i;
                r_seg   <= x_i[DATA_WIDTH-1 -: SEG_BITS];
                r_k     <= '0;
                r_p     <= ONE_Q;
            end
        end else if (w_push) begin
            r_p     <= w_p_next;
            r_k     <= w_last ? '0 : r_k + 1'b1;
            r_state <= w_last ? ST_IDLE : ST_EMIT;
        end
    end

    // Coefficient bank: writes only land while idle and with an in-range term index
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            for (int i = 0; i < NW; i++) r_bank[i] <= '0;
        end else if (w_cfg_ok) begin
            r_bank[w_widx] <= cfg_data_i;
        end
    end

    // Rejected config writes are flagged one cycle later
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) r_cfg_err <= 1'b0;
        else         r_cfg_err <= cfg_we_i && !w_cfg_ok;
    end
endmodule
